// File: rtl/aes_buf_pkg.sv
// Shared types and sizes for the AES block input/output buffers.
package aes_buf_pkg;

  localparam int unsigned AES_BLK_W     = 128;
  localparam int unsigned AES_WORD_W    = 32;
  localparam int unsigned AES_NUM_WORDS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } obuf_state_t;

  typedef logic [1:0] aes_widx_t;

endpackage

// File: rtl/aes_obuf_word_sel.sv
// Selects one word of the held 128-bit block; MSW_FIRST reverses word order.
module aes_obuf_word_sel
  import aes_buf_pkg::*;
#(
  parameter int unsigned MSW_FIRST = 0
) (
  input  logic [AES_BLK_W-1:0]  blk,
  input  aes_widx_t             idx,
  output logic [AES_WORD_W-1:0] word
);

  aes_widx_t sel;

  // Map the transmit index to a physical word slot, then pick that slot.
  always_comb begin
    sel  = (MSW_FIRST != 0) ? aes_widx_t'(aes_widx_t'(AES_NUM_WORDS - 1) - idx) : idx;
    word = '0;
    for (int k = 0; k < int'(AES_NUM_WORDS); k++) begin
      if (sel == aes_widx_t'(k)) word = blk[k*AES_WORD_W +: AES_WORD_W];
    end
  end

endmodule

// File: rtl/aes_output_buffer.sv
// Captures the AES core result on done_i and drains it as four 32-bit words
// over valid/ready, pulsing done_o once the final word is accepted.
// Optional: define AES_OBUF_SKID_EN to add a one-block skid register that
// absorbs a done_i arriving while a block is still draining.
module aes_output_buffer
  import aes_buf_pkg::*;
#(
  parameter int unsigned MSW_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_i,
  input  logic [AES_BLK_W-1:0]  text_i,
  output logic [AES_WORD_W-1:0] text_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  last_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  overflow_o
);

  localparam aes_widx_t LAST_IDX = aes_widx_t'(AES_NUM_WORDS - 1);

  obuf_state_t          state, state_n;
  aes_widx_t            idx, idx_n;
  logic [AES_BLK_W-1:0] hold, hold_n;
  logic                 done_n;
  logic                 ovf_n;
  logic [AES_WORD_W-1:0] word_n;
  logic                 hs;
  logic                 last_hs;
`ifdef AES_OBUF_SKID_EN
  logic [AES_BLK_W-1:0] skid, skid_n;
  logic                 skid_v, skid_v_n;
`endif

  assign hs      = out_valid_o & out_ready_i;
  assign last_hs = hs && (idx == LAST_IDX);

  // Word presented in the next cycle, so text_o can be registered.
  aes_obuf_word_sel #(
    .MSW_FIRST (MSW_FIRST)
  ) u_word_sel (
    .blk  (hold_n),
    .idx  (idx_n),
    .word (word_n)
  );

  // Next-state, index, hold/skid and flag decisions.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    hold_n  = hold;
    done_n  = 1'b0;
    ovf_n   = overflow_o;
`ifdef AES_OBUF_SKID_EN
    skid_n   = skid;
    skid_v_n = skid_v;
`endif
    case (state)
      IDLE: begin
        if (done_i) begin
          hold_n  = text_i;
          idx_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (hs && !last_hs) idx_n = aes_widx_t'(idx + aes_widx_t'(1));
        if (last_hs) begin
          done_n = 1'b1;
          idx_n  = '0;
`ifdef AES_OBUF_SKID_EN
          if (skid_v) begin
            hold_n   = skid;
            skid_v_n = done_i;
            if (done_i) skid_n = text_i;
          end else if (done_i) begin
            hold_n = text_i;
          end else begin
            state_n = IDLE;
          end
`else
          if (done_i) hold_n = text_i;
          else        state_n = IDLE;
`endif
        end else if (done_i) begin
`ifdef AES_OBUF_SKID_EN
          if (!skid_v) begin
            skid_n   = text_i;
            skid_v_n = 1'b1;
          end else begin
            ovf_n = 1'b1;
          end
`else
          ovf_n = 1'b1;
`endif
        end
      end
    endcase
  end

  // State register and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      hold        <= '0;
      text_o      <= '0;
      out_valid_o <= 1'b0;
      last_o      <= 1'b0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
      overflow_o  <= 1'b0;
`ifdef AES_OBUF_SKID_EN
      skid        <= '0;
      skid_v      <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      hold        <= hold_n;
      text_o      <= (state_n == SEND) ? word_n : '0;
      out_valid_o <= (state_n == SEND);
      last_o      <= (state_n == SEND) && (idx_n == LAST_IDX);
      done_o      <= done_n;
      busy_o      <= (state_n == SEND);
      overflow_o  <= ovf_n;
`ifdef AES_OBUF_SKID_EN
      skid        <= skid_n;
      skid_v      <= skid_v_n;
`endif
    end
  end

endmodule

// File: tb/tb_aes_output_buffer.sv
// Directed bench for aes_output_buffer (LSW-first main instance plus an
// MSW-first instance sharing the same stimulus).
module tb_aes_output_buffer;

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000001;

  logic         clk = 1'b0;
  logic         rst;
  logic         done_i;
  logic [127:0] text_i;
  logic         out_ready_i;

  logic [31:0]  text_o;
  logic         out_valid_o, last_o, done_o, busy_o, overflow_o;
  logic [31:0]  m_text_o;
  logic         m_out_valid_o, m_last_o, m_done_o, m_busy_o, m_overflow_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_output_buffer #(.MSW_FIRST(0)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .text_i(text_i),
    .text_o(text_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .last_o(last_o), .done_o(done_o), .busy_o(busy_o), .overflow_o(overflow_o)
  );

  aes_output_buffer #(.MSW_FIRST(1)) dut_msw (
    .clk(clk), .rst(rst), .done_i(done_i), .text_i(text_i),
    .text_o(m_text_o), .out_valid_o(m_out_valid_o), .out_ready_i(out_ready_i),
    .last_o(m_last_o), .done_o(m_done_o), .busy_o(m_busy_o), .overflow_o(m_overflow_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [31:0] w, input logic lst);
    check({tag, ".valid"}, 128'(out_valid_o), 128'(1'b1));
    check({tag, ".text"},  128'(text_o),      128'(w));
    check({tag, ".last"},  128'(last_o),      128'(lst));
    check({tag, ".done"},  128'(done_o),      128'(1'b0));
  endtask

  // Drain words from..3 of blk with ready high; ends in the done_o cycle.
  task automatic drain_rest(input string tag, input logic [127:0] blk, input int from);
    for (int k = from; k < 4; k++) begin
      check_word(tag, blk[32*k +: 32], k == 3);
      step;
    end
    check({tag, ".done_pulse"}, 128'(done_o), 128'(1'b1));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".text"},  128'(text_o),      128'(0));
    check({tag, ".valid"}, 128'(out_valid_o), 128'(0));
    check({tag, ".last"},  128'(last_o),      128'(0));
    check({tag, ".done"},  128'(done_o),      128'(0));
    check({tag, ".busy"},  128'(busy_o),      128'(0));
    check({tag, ".ovf"},   128'(overflow_o),  128'(0));
  endtask

  initial begin
    logic [31:0] exp_m [4];
    exp_m = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

    rst = 1'b0; done_i = 1'b0; text_i = '0; out_ready_i = 1'b0;
    step; step;
    check_idle_zero("reset");
    check("reset.m_valid", 128'(m_out_valid_o), 128'(0));
    rst = 1'b1;
    step;

    // Basic drain with ready held high
    out_ready_i = 1'b1;
    done_i = 1'b1; text_i = BLK_A;
    step;
    done_i = 1'b0; text_i = '0;
    check("basic.busy", 128'(busy_o), 128'(1));
    check_word("basic.w0", 32'hCCDDEEFF, 1'b0); step;
    check_word("basic.w1", 32'h8899AABB, 1'b0); step;
    check_word("basic.w2", 32'h44556677, 1'b0); step;
    check_word("basic.w3", 32'h00112233, 1'b1); step;
    check("basic.done",  128'(done_o),      128'(1));
    check("basic.valid", 128'(out_valid_o), 128'(0));
    check("basic.busy0", 128'(busy_o),      128'(0));
    step;
    check("basic.done_once", 128'(done_o), 128'(0));

    // Backpressure on word 1
    done_i = 1'b1; text_i = BLK_A;
    step;
    done_i = 1'b0;
    check_word("bp.w0", 32'hCCDDEEFF, 1'b0); step;
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_word("bp.stall", 32'h8899AABB, 1'b0);
      step;
    end
    out_ready_i = 1'b1;
    drain_rest("bp", BLK_A, 1);
    check("bp.valid_end", 128'(out_valid_o), 128'(0));
    step;
    check("bp.done_once", 128'(done_o), 128'(0));

    // Back-to-back: new block on the last handshake
    done_i = 1'b1; text_i = BLK_A;
    step;
    done_i = 1'b0;
    check_word("b2b.w0", 32'hCCDDEEFF, 1'b0); step;
    check_word("b2b.w1", 32'h8899AABB, 1'b0); step;
    check_word("b2b.w2", 32'h44556677, 1'b0); step;
    check_word("b2b.w3", 32'h00112233, 1'b1);
    done_i = 1'b1; text_i = BLK_B;
    step;
    done_i = 1'b0; text_i = '0;
    check("b2b.done1", 128'(done_o),      128'(1));
    check("b2b.valid", 128'(out_valid_o), 128'(1));
    check("b2b.nw0",   128'(text_o),      128'(32'h00000001));
    check("b2b.last",  128'(last_o),      128'(0));
    step;
    drain_rest("b2b.B", BLK_B, 1);
    check("b2b.valid_end", 128'(out_valid_o), 128'(0));
    step;

    // done_i arriving during word 1
    done_i = 1'b1; text_i = BLK_A;
    step;
    done_i = 1'b0;
    check_word("ovf.w0", 32'hCCDDEEFF, 1'b0); step;
    check_word("ovf.w1", 32'h8899AABB, 1'b0);
    done_i = 1'b1; text_i = BLK_B;
    step;
    done_i = 1'b0; text_i = '0;
`ifdef AES_OBUF_SKID_EN
    check("ovf.skid_noovf", 128'(overflow_o), 128'(0));
    drain_rest("ovf.A", BLK_A, 2);
    check("ovf.skid_valid", 128'(out_valid_o), 128'(1));
    check("ovf.skid_w0",    128'(text_o),      128'(32'h00000001));
    step;
    drain_rest("ovf.B", BLK_B, 1);
    check("ovf.skid_end", 128'(out_valid_o), 128'(0));
    check("ovf.skid_ovf", 128'(overflow_o),  128'(0));
`else
    check("ovf.set", 128'(overflow_o), 128'(1));
    drain_rest("ovf.A", BLK_A, 2);
    check("ovf.dropped", 128'(out_valid_o), 128'(0));
    check("ovf.sticky",  128'(overflow_o),  128'(1));
    step;
    check("ovf.sticky2", 128'(overflow_o), 128'(1));
    check("ovf.idle",    128'(busy_o),     128'(0));
`endif
    step;

    // Reset mid-block, with done_i asserted during reset
    done_i = 1'b1; text_i = BLK_A;
    step;
    done_i = 1'b0;
    check_word("rstm.w0", 32'hCCDDEEFF, 1'b0); step;
    check_word("rstm.w1", 32'h8899AABB, 1'b0);
    rst = 1'b0; done_i = 1'b1; text_i = BLK_B;
    step;
    done_i = 1'b0; text_i = '0;
    check_idle_zero("rstm");
    rst = 1'b1;
    step;
    check("rstm.nodone",  128'(done_o),      128'(0));
    check("rstm.novalid", 128'(out_valid_o), 128'(0));
    done_i = 1'b1; text_i = BLK_A;
    step;
    done_i = 1'b0;
    drain_rest("rstm.post", BLK_A, 0);
    check("rstm.post_end", 128'(out_valid_o), 128'(0));
    step;

    // MSW-first instance ordering
    done_i = 1'b1; text_i = BLK_A;
    step;
    done_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("msw.valid", 128'(m_out_valid_o), 128'(1));
      check("msw.text",  128'(m_text_o),      128'(exp_m[k]));
      check("msw.last",  128'(m_last_o),      128'(k == 3));
      step;
    end
    check("msw.done", 128'(m_done_o), 128'(1));
    step;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
